aes_byte_ctrl: RTL and testbench
================================

# aes_byte_ctrl

Sequencer for the byte-serial iterative AES-128 datapath. It drives the write-mux select, the double-banked 16-byte state memory addresses and write enable, and the key-schedule step strobe. It steps one plaintext block through load, 10 rounds and unload. The block sits directly upstream of the 5-to-1 state write mux and owns every control input of that mux and of the state memory.

## Interface
Parameters:
- `NROUNDS`, 10, number of AES rounds (AES-128).

Ports:
- `clk  in  1  clock`
- `rst  in  1  synchronous, active-high reset`
- `start  in  1  begin a block; honoured only in IDLE`
- `busy  out  1  high in every state except IDLE`
- `din_req  out  1  plaintext byte consumed this cycle (LOAD)`
- `wr_sel  out  3  write-mux select: 0 buffered read (ShiftRows), 1 din^key, 2 sbox, 3 mixcolumns, 4 AddRoundKey`
- `wr_en  out  1  state memory write enable`
- `wr_addr  out  5  {bank, byte index}`
- `rd_addr  out  5  {bank, byte index}`
- `mix_shift  out  1  shift the read byte into the mixcolumns column register`
- `mix_row  out  2  row of the mixed column presented on mux port 3`
- `key_next  out  1  one-cycle pulse: advance key schedule to next round key`
- `round  out  4  current round, 0..NROUNDS`
- `dout_valid  out  1  read data of the state memory is a ciphertext byte`
- `done  out  1  one-cycle pulse, block complete`

## Operation
- States: IDLE, LOAD, SUB, SHIFT, MIX, ARK, OUT.
- Banks:
  - Every pass reads bank `b` and writes bank `~b`.
  - `b` toggles at the end of each pass.
  - LOAD writes bank 0.
- IDLE:
  - `start` → LOAD, with `round`=0, byte counter 0.
- LOAD:
  - 16 cycles, `din_req`=1, `wr_sel`=1, `wr_en`=1, `wr_addr`={0,k} for k=0..15.
  - Initial AddRoundKey is folded into this pass.
  - After LOAD: `round`=1, then SUB.
- Read passes (SUB, SHIFT, ARK):
  - 17 cycles each.
  - Cycle k=0..15 issues `rd_addr`.
  - Memory read and mux port 0 are registered, so the write for byte k occurs at cycle k+1 with `wr_addr`={~b,k}.
  - `wr_en` is low on cycle 0.
- SHIFT read order:
  - `rd_addr` index = (k + 4·(k mod 4)) mod 16 (column-major ShiftRows), `wr_sel`=0.
- SUB and ARK:
  - Identity order; `wr_sel`=2 and 4 respectively.
- MIX:
  - 21 cycles.
  - Reads bytes 0..15 at cycles 0..15 with `mix_shift`=1 on cycles 1..16.
  - Column c writes bytes 4c..4c+3 at cycles 4c+5..4c+8, with `mix_row`=0..3 and `wr_sel`=3.
- Round sequence:
  - Rounds 1..NROUNDS-1: SUB→SHIFT→MIX→ARK.
  - Round NROUNDS: SUB→SHIFT→ARK (no MIX).
  - After each ARK, `round` increments; the last ARK goes to OUT.
- `key_next`:
  - Pulses in the first cycle of each SUB, once per round 1..NROUNDS.
  - Key schedule then has SUB+SHIFT(+MIX) time before ARK.
- OUT:
  - 17 cycles; `rd_addr` index 0..15 on cycles 0..15.
  - `dout_valid` on cycles 1..16.
  - `done` coincides with the last `dout_valid`; next state is IDLE.

## Timing
- Reset: state IDLE, all outputs 0, `round`=0, bank 0, counters 0.
- Reset is effective the cycle after `rst` is sampled, including mid-block. The partial block is discarded and no `done` is issued.
- `start` is sampled at cycle 0. Schedule:
  - LOAD occupies cycles 1..16.
  - Rounds 1–9 take 72 cycles each.
  - Round 10 takes 51 cycles.
  - OUT occupies cycles 716..732.
  - `done` is at cycle 732.
- `start` while `busy` is ignored.
- `start` in the same cycle as `done` is ignored, since the FSM is not yet in IDLE.
- `start` in the cycle after `done` is accepted.
- `wr_en` and `dout_valid` never assert in IDLE.
- `wr_addr` and `rd_addr` hold their last value when not in use.
- The byte counter wraps only via state transition, never silently.
- `round` is 4 bits and saturates at NROUNDS, which cannot be exceeded.

## Structure
- Shared package `aes_pkg`:
  - state enum;
  - `wr_sel` encodings (SEL_BUF, SEL_DIN, SEL_SBOX, SEL_MIX, SEL_ARK);
  - pass lengths (16, 17, 21);
  - the ShiftRows index function.
- One sub-module, `aes_addr_gen`: byte counter plus bank bit, producing `rd_addr`/`wr_addr` for the current pass type.
- The FSM stays in `aes_byte_ctrl`.

## Test plan
- Reset then `start`: `din_req` high exactly cycles 1..16, `wr_addr` 0..15 with bank 0, `wr_sel`=1, `done` at cycle 732.
- SHIFT pass of round 1: `rd_addr` indices 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11; write index k one cycle after each read; banks opposite.
- MIX pass: `mix_shift` high on 16 consecutive cycles; writes at cycles 5..8, 9..12, 13..16, 17..20 with `mix_row` cycling 0..3. No MIX in round 10.
- `key_next` pulse count is 10 per block; each pulse is the first cycle of SUB; `round` reads 1..10 across them.
- `start` asserted continuously: second block begins at cycle 733 (LOAD at 734), no extra `done`.
- `rst` asserted at cycle 300: next cycle all outputs 0 and IDLE; a fresh `start` yields `done` 732 cycles later.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the byte-serial AES-128 control slice.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUB,
        SHIFT,
        MIX,
        ARK,
        OUT
    } state_e;

    localparam logic [2:0] SEL_BUF  = 3'd0;
    localparam logic [2:0] SEL_DIN  = 3'd1;
    localparam logic [2:0] SEL_SBOX = 3'd2;
    localparam logic [2:0] SEL_MIX  = 3'd3;
    localparam logic [2:0] SEL_ARK  = 3'd4;

    localparam logic [4:0] LEN_LOAD = 5'd16;
    localparam logic [4:0] LEN_READ = 5'd17;
    localparam logic [4:0] LEN_MIX  = 5'd21;

    function automatic logic [4:0] pass_len(input state_e s);
        case (s)
            LOAD:    return LEN_LOAD;
            MIX:     return LEN_MIX;
            IDLE:    return 5'd1;
            default: return LEN_READ;
        endcase
    endfunction

    // Column-major ShiftRows: index k reads (k + 4*(k mod 4)) mod 16.
    function automatic logic [3:0] shift_idx(input logic [3:0] k);
        return k + {k[1:0], 2'b00};
    endfunction

    function automatic logic [2:0] sel_for(input state_e s);
        case (s)
            LOAD:    return SEL_DIN;
            SUB:     return SEL_SBOX;
            MIX:     return SEL_MIX;
            ARK:     return SEL_ARK;
            default: return SEL_BUF;
        endcase
    endfunction

endpackage

// File: rtl/aes_addr_gen.sv
// Byte counter and bank bit; produces registered state-memory addresses
// for the cycle the FSM is about to enter.
module aes_addr_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  state_e     state,
    input  state_e     state_nxt,
    output logic       last,
    output logic [4:0] cnt_nxt,
    output logic [4:0] rd_addr,
    output logic [4:0] wr_addr
);

    logic [4:0] cnt;
    logic       bank;
    logic       bank_nxt;
    logic [3:0] k4;
    logic [3:0] k_m1;
    logic [3:0] k_m5;

    assign last = (cnt == pass_len(state) - 5'd1);

    // A pass only ends through a state change, so the count never wraps in place.
    always_comb begin
        cnt_nxt  = 5'd0;
        bank_nxt = bank;
        if (state_nxt == state && state != IDLE)
            cnt_nxt = cnt + 5'd1;
        if (state_nxt == LOAD)
            bank_nxt = 1'b0;
        else if (state_nxt != state && state inside {SUB, SHIFT, MIX, ARK})
            bank_nxt = ~bank;
    end

    assign k4   = cnt_nxt[3:0];
    assign k_m1 = cnt_nxt[3:0] - 4'd1;
    assign k_m5 = cnt_nxt[3:0] - 4'd5;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 5'd0;
            bank    <= 1'b0;
            rd_addr <= 5'd0;
            wr_addr <= 5'd0;
        end else begin
            cnt  <= cnt_nxt;
            bank <= bank_nxt;
            case (state_nxt)
                LOAD: wr_addr <= {1'b0, k4};
                SUB, ARK: begin
                    if (!cnt_nxt[4]) rd_addr <= {bank_nxt, k4};
                    if (cnt_nxt != 5'd0) wr_addr <= {~bank_nxt, k_m1};
                end
                SHIFT: begin
                    if (!cnt_nxt[4]) rd_addr <= {bank_nxt, shift_idx(k4)};
                    if (cnt_nxt != 5'd0) wr_addr <= {~bank_nxt, k_m1};
                end
                MIX: begin
                    if (!cnt_nxt[4]) rd_addr <= {bank_nxt, k4};
                    if (cnt_nxt >= 5'd5) wr_addr <= {~bank_nxt, k_m5};
                end
                OUT: begin
                    if (!cnt_nxt[4]) rd_addr <= {bank_nxt, k4};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/aes_byte_ctrl.sv
// Sequencer for the byte-serial iterative AES-128 datapath: one block through
// load, NROUNDS rounds and unload, with all outputs registered.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | 16 plaintext bytes written as din^key into bank 0
//   SUB   | SubBytes pass, key schedule stepped on first cycle
//   SHIFT | ShiftRows pass via permuted read order
//   MIX   | MixColumns pass, column register fed then drained
//   ARK   | AddRoundKey pass, round advances at its end
//   OUT   | ciphertext bytes read out, done on the last one
module aes_byte_ctrl
    import aes_pkg::*;
#(
    parameter int NROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       din_req,
    output logic [2:0] wr_sel,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic [4:0] rd_addr,
    output logic       mix_shift,
    output logic [1:0] mix_row,
    output logic       key_next,
    output logic [3:0] round,
    output logic       dout_valid,
    output logic       done
);

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

    state_e     state;
    state_e     state_nxt;
    logic [3:0] round_nxt;
    logic       last;
    logic [4:0] k;

    aes_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .state_nxt (state_nxt),
        .last      (last),
        .cnt_nxt   (k),
        .rd_addr   (rd_addr),
        .wr_addr   (wr_addr)
    );

    always_comb begin
        state_nxt = state;
        round_nxt = round;
        unique case (state)
            IDLE: if (start) begin
                state_nxt = LOAD;
                round_nxt = 4'd0;
            end
            LOAD: if (last) begin
                state_nxt = SUB;
                round_nxt = 4'd1;
            end
            SUB:   if (last) state_nxt = SHIFT;
            SHIFT: if (last) state_nxt = (round >= LAST_ROUND) ? ARK : MIX;
            MIX:   if (last) state_nxt = ARK;
            ARK: if (last) begin
                if (round >= LAST_ROUND) begin
                    state_nxt = OUT;
                end else begin
                    state_nxt = SUB;
                    round_nxt = round + 4'd1;
                end
            end
            OUT:   if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the state/count being entered so they line up
    // with the registered state in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            round      <= 4'd0;
            busy       <= 1'b0;
            din_req    <= 1'b0;
            wr_sel     <= SEL_BUF;
            wr_en      <= 1'b0;
            mix_shift  <= 1'b0;
            mix_row    <= 2'd0;
            key_next   <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            round      <= round_nxt;
            busy       <= (state_nxt != IDLE);
            din_req    <= (state_nxt == LOAD);
            wr_sel     <= sel_for(state_nxt);
            key_next   <= (state_nxt == SUB) && (state != SUB);
            mix_shift  <= (state_nxt == MIX) && (k >= 5'd1) && (k <= 5'd16);
            mix_row    <= ((state_nxt == MIX) && (k >= 5'd5)) ? (k[1:0] - 2'd1) : 2'd0;
            dout_valid <= (state_nxt == OUT) && (k != 5'd0);
            done       <= (state_nxt == OUT) && (k == 5'd16);
            case (state_nxt)
                LOAD:            wr_en <= 1'b1;
                SUB, SHIFT, ARK: wr_en <= (k != 5'd0);
                MIX:             wr_en <= (k >= 5'd5);
                default:         wr_en <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_byte_ctrl.sv
// Directed bench for aes_byte_ctrl: single block schedule, back-to-back start,
// and mid-block reset, with expected cycles worked out by hand.
module tb_aes_byte_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       din_req;
    logic [2:0] wr_sel;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [4:0] rd_addr;
    logic       mix_shift;
    logic [1:0] mix_row;
    logic       key_next;
    logic [3:0] round;
    logic       dout_valid;
    logic       done;

    int total = 0;
    int passed = 0;
    int failed = 0;
    int cyc = 0;

    int shift_tab [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    aes_byte_ctrl #(.NROUNDS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .din_req    (din_req),
        .wr_sel     (wr_sel),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .mix_shift  (mix_shift),
        .mix_row    (mix_row),
        .key_next   (key_next),
        .round      (round),
        .dout_valid (dout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s @cyc %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [25:0] all_outs();
        return {busy, din_req, wr_en, wr_sel, wr_addr, rd_addr, mix_shift,
                mix_row, key_next, round, dout_valid, done};
    endfunction

    initial begin
        int din_cnt, din_first, din_last, kn, mix_cnt, done_cnt, done_cyc, dv_cnt, idle_bad;

        rst = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", 32'(all_outs()), 32'd0);

        // Block 1: single start pulse, full schedule
        din_cnt = 0; din_first = -1; din_last = -1; kn = 0; mix_cnt = 0;
        done_cnt = 0; done_cyc = -1; dv_cnt = 0; idle_bad = 0;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 740; i++) begin
            if (din_req) begin
                din_cnt++;
                if (din_first < 0) din_first = cyc;
                din_last = cyc;
            end
            if (cyc >= 1 && cyc <= 16) begin
                check("load_wr_addr", 32'(wr_addr), 32'(cyc - 1));
                check("load_wr_sel", 32'(wr_sel), 32'd1);
                check("load_wr_en", 32'(wr_en), 32'd1);
            end
            if (cyc >= 34 && cyc <= 49)
                check("shift_rd_addr", 32'(rd_addr), 32'(16 + shift_tab[cyc - 34]));
            if (cyc == 34)
                check("shift_wr_en_c0", 32'(wr_en), 32'd0);
            if (cyc >= 35 && cyc <= 50) begin
                check("shift_wr_addr", 32'(wr_addr), 32'(cyc - 35));
                check("shift_wr_sel", 32'(wr_sel), 32'd0);
            end
            if (cyc >= 51 && cyc <= 71) begin
                check("mix_shift_win", 32'(mix_shift), 32'(cyc >= 52 && cyc <= 67));
                check("mix_wr_en", 32'(wr_en), 32'(cyc >= 56));
            end
            if (cyc >= 56 && cyc <= 71) begin
                check("mix_wr_addr", 32'(wr_addr), 32'(16 + cyc - 56));
                check("mix_row", 32'(mix_row), 32'((cyc - 56) % 4));
                check("mix_wr_sel", 32'(wr_sel), 32'd3);
            end
            if (cyc == 700)
                check("r10_ark_sel", 32'(wr_sel), 32'd4);
            if (cyc == 716)
                check("out_rd_first", 32'(rd_addr), 32'd16);
            if (cyc == 731)
                check("out_rd_last", 32'(rd_addr), 32'd31);
            if (key_next) begin
                kn++;
                check("key_next_round", 32'(round), 32'(kn));
                check("key_next_cycle", 32'(cyc), 32'(17 + 72 * (kn - 1)));
            end
            if (mix_shift) mix_cnt++;
            if (dout_valid) dv_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!busy && (wr_en || dout_valid)) idle_bad++;
            tick();
        end
        check("din_req_count", 32'(din_cnt), 32'd16);
        check("din_req_first", 32'(din_first), 32'd1);
        check("din_req_last", 32'(din_last), 32'd16);
        check("key_next_count", 32'(kn), 32'd10);
        check("mix_shift_count", 32'(mix_cnt), 32'd144);
        check("dout_valid_count", 32'(dv_cnt), 32'd16);
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'd732);
        check("idle_activity", 32'(idle_bad), 32'd0);
        check("idle_after_block", 32'(busy), 32'd0);

        // Block 2: start held high throughout
        done_cnt = 0; din_cnt = 0;
        start = 1'b1;
        cyc = 0;
        tick();
        for (int i = 0; i < 745; i++) begin
            if (done) done_cnt++;
            if (din_req && cyc <= 732) din_cnt++;
            if (cyc == 733) begin
                check("b2b_idle_busy", 32'(busy), 32'd0);
                check("b2b_idle_din", 32'(din_req), 32'd0);
            end
            if (cyc == 734) begin
                check("b2b_load_din", 32'(din_req), 32'd1);
                check("b2b_load_addr", 32'(wr_addr), 32'd0);
            end
            tick();
        end
        start = 1'b0;
        check("b2b_done_count", 32'(done_cnt), 32'd1);
        check("b2b_din_count", 32'(din_cnt), 32'd16);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("reset_between", 32'(all_outs()), 32'd0);

        // Block 3: reset in the middle of a block
        done_cnt = 0;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        while (cyc < 300) begin
            if (done) done_cnt++;
            tick();
        end
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("midblock_reset_outs", 32'(all_outs()), 32'd0);
        rst = 1'b0;
        tick();
        check("post_reset_idle", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_load", 32'(din_req), 32'd1);
        done_cyc = -1;
        while (cyc < 1045) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            tick();
        end
        check("restart_done_count", 32'(done_cnt), 32'd1);
        check("restart_done_cycle", 32'(done_cyc), 32'd1034);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
